// File: rtl/calc_seq_n.sv
// Serial reduction calculator: folds NUM_OPS unsigned operands into a sum, max,
// min or range result, with valid/ready handshakes on operands and result.
module calc_seq_n #(
   parameter int DATA_W  = 6,
   parameter int NUM_OPS = 6,
   parameter int OUT_W   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              start_ready,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              overflow,
   output logic              busy
);

   localparam int CNT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int SUM_W = OUT_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

   localparam logic [1:0] MODE_SUM   = 2'd0;
   localparam logic [1:0] MODE_MAX   = 2'd1;
   localparam logic [1:0] MODE_MIN   = 2'd2;
   localparam logic [1:0] MODE_RANGE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [1:0]          mode_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [OUT_W-1:0]    sum_r;
   logic                acc_ovf_r;
   logic [DATA_W-1:0]   max_r;
   logic [DATA_W-1:0]   min_r;
   logic [OUT_W-1:0]    out_data_r;
   logic                overflow_r;
   logic                out_valid_r;
   logic                in_ready_r;
   logic                busy_r;

   logic                start_acc_s;
   logic                op_acc_s;
   logic                last_op_s;
   logic [SUM_W-1:0]    sum_ext_s;
   logic                ovf_next_s;
   logic [DATA_W-1:0]   max_next_s;
   logic [DATA_W-1:0]   min_next_s;
   logic [OUT_W-1:0]    result_s;
   logic                res_ovf_s;

   // Next-state decode and handshake acceptance strobes.
   always_comb begin
      state_s     = state_r;
      start_acc_s = 1'b0;
      op_acc_s    = 1'b0;
      last_op_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               start_acc_s = 1'b1;
               state_s     = ST_ACCUM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               op_acc_s = 1'b1;
               if (cnt_r == LAST_CNT) begin
                  last_op_s = 1'b1;
                  state_s   = ST_DONE;
               end else begin
                  state_s = ST_ACCUM;
               end
            end else begin
               state_s = ST_ACCUM;
            end
         end
         ST_DONE: begin
            // Consuming the result and starting the next operation share a cycle.
            if (out_ready) begin
               if (start) begin
                  start_acc_s = 1'b1;
                  state_s     = ST_ACCUM;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Accumulator, extremes and the result they would produce with the current operand.
   always_comb begin
      sum_ext_s  = {1'b0, sum_r} + SUM_W'(in_data);
      ovf_next_s = acc_ovf_r | sum_ext_s[OUT_W];
      if (in_data > max_r) begin
         max_next_s = in_data;
      end else begin
         max_next_s = max_r;
      end
      if (in_data < min_r) begin
         min_next_s = in_data;
      end else begin
         min_next_s = min_r;
      end
      result_s  = {OUT_W{1'b0}};
      res_ovf_s = 1'b0;
      case (mode_r)
         MODE_SUM: begin
            result_s  = sum_ext_s[OUT_W-1:0];
            res_ovf_s = ovf_next_s;
         end
         MODE_MAX: begin
            result_s = OUT_W'(max_next_s);
         end
         MODE_MIN: begin
            result_s = OUT_W'(min_next_s);
         end
         MODE_RANGE: begin
            result_s = OUT_W'(max_next_s - min_next_s);
         end
         default: begin
            result_s  = {OUT_W{1'b0}};
            res_ovf_s = 1'b0;
         end
      endcase
   end

   // State register plus registered decodes of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         in_ready_r <= (state_s == ST_ACCUM);
         busy_r     <= (state_s != ST_IDLE);
      end
   end

   // Operation context: latched mode, operand count and running reductions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r    <= 2'd0;
         cnt_r     <= {CNT_W{1'b0}};
         sum_r     <= {OUT_W{1'b0}};
         acc_ovf_r <= 1'b0;
         max_r     <= {DATA_W{1'b0}};
         min_r     <= {DATA_W{1'b0}};
      end else if (start_acc_s) begin
         mode_r    <= mode;
         cnt_r     <= {CNT_W{1'b0}};
         sum_r     <= {OUT_W{1'b0}};
         acc_ovf_r <= 1'b0;
         max_r     <= {DATA_W{1'b0}};
         min_r     <= {DATA_W{1'b1}};
      end else if (op_acc_s) begin
         sum_r     <= sum_ext_s[OUT_W-1:0];
         acc_ovf_r <= ovf_next_s;
         max_r     <= max_next_s;
         min_r     <= min_next_s;
         // Hold on the final operand so the counter never wraps.
         if (!last_op_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Result registers: loaded only on entry to DONE, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= {OUT_W{1'b0}};
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (last_op_s) begin
         out_data_r  <= result_s;
         overflow_r  <= res_ovf_s;
         out_valid_r <= 1'b1;
      end else if ((state_r == ST_DONE) && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // start_ready follows out_ready combinationally in DONE; held low during reset.
   assign start_ready = rst_n & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_calc_seq_n.sv
// Scoreboard bench for calc_seq_n: default build, a 6-bit-result build sharing
// its stimulus, and a single-operand build.
module tb_calc_seq_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, in_valid_a, out_ready_a;
   logic [1:0] mode_a;
   logic [5:0] in_data_a;

   logic       sr0, ir0, ov0, ovf0, busy0;
   logic [9:0] od0;
   logic       sr1, ir1, ov1, ovf1, busy1;
   logic [5:0] od1;

   logic       start_c, iv_c, or_c;
   logic [1:0] mode_c;
   logic [5:0] id_c;
   logic       sr2, ir2, ov2, ovf2, busy2;
   logic [9:0] od2;

   int n_chk = 0;
   int n_fail = 0;

   logic [10:0] q0[$];
   logic [10:0] q1[$];
   logic [10:0] q2[$];

   calc_seq_n dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_a), .start_ready(sr0), .mode(mode_a),
      .in_valid(in_valid_a), .in_ready(ir0), .in_data(in_data_a), .out_valid(ov0),
      .out_ready(out_ready_a), .out_data(od0), .overflow(ovf0), .busy(busy0)
   );

   calc_seq_n #(.DATA_W(6), .NUM_OPS(6), .OUT_W(6)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_a), .start_ready(sr1), .mode(mode_a),
      .in_valid(in_valid_a), .in_ready(ir1), .in_data(in_data_a), .out_valid(ov1),
      .out_ready(out_ready_a), .out_data(od1), .overflow(ovf1), .busy(busy1)
   );

   calc_seq_n #(.DATA_W(6), .NUM_OPS(1), .OUT_W(10)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_c), .start_ready(sr2), .mode(mode_c),
      .in_valid(iv_c), .in_ready(ir2), .in_data(id_c), .out_valid(ov2),
      .out_ready(or_c), .out_data(od2), .overflow(ovf2), .busy(busy2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (bit 10 = overflow for results)", nm, act, exp);
      end
   endtask

   // Monitor: compare every presented result against the queue head.
   always @(negedge clk) begin
      if (rst_n && ov0) begin
         chk("dut0_pending", 32'(q0.size() > 0), 32'd1);
         if (q0.size() > 0) begin
            chk("dut0_result", {ovf0, od0}, q0[0]);
            if (out_ready_a) void'(q0.pop_front());
         end
      end
      if (rst_n && ov1) begin
         chk("dut1_pending", 32'(q1.size() > 0), 32'd1);
         if (q1.size() > 0) begin
            chk("dut1_result", {ovf1, 4'b0000, od1}, q1[0]);
            if (out_ready_a) void'(q1.pop_front());
         end
      end
      if (rst_n && ov2) begin
         chk("dut2_pending", 32'(q2.size() > 0), 32'd1);
         if (q2.size() > 0) begin
            chk("dut2_result", {ovf2, od2}, q2[0]);
            if (or_c) void'(q2.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ops packs six operands, first operand in the top bits.
   task automatic op_a(input logic [1:0] m, input logic [35:0] ops, input bit bub,
                       input logic [10:0] e0, input logic [10:0] e1);
      q0.push_back(e0);
      q1.push_back(e1);
      start_a = 1'b1; mode_a = m; in_valid_a = 1'b0; out_ready_a = 1'b1;
      chk("start_ready", sr0, 1);
      cyc();
      start_a = 1'b0; mode_a = ~m;
      for (int i = 0; i < 6; i++) begin
         if (bub) begin
            in_valid_a = 1'b0; in_data_a = 6'd63;
            cyc();
         end
         in_valid_a = 1'b1; in_data_a = ops[35-6*i -: 6];
         chk("in_ready", ir0, 1);
         chk("early_valid", ov0, 0);
         cyc();
      end
      in_valid_a = 1'b0;
      chk("latency_valid", ov0, 1);
      chk("latency_valid_w6", ov1, 1);
   endtask

   task automatic drain(input int stall);
      for (int i = 0; i < stall; i++) begin
         out_ready_a = 1'b0; start_a = 1'b1; in_valid_a = 1'b1; in_data_a = 6'd63; mode_a = 2'd0;
         #1;
         chk("bp_in_ready", ir0, 0);
         chk("bp_start_ready", sr0, 0);
         chk("bp_valid", ov0, 1);
         cyc();
      end
      start_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
      cyc();
      chk("valid_one_cycle", ov0, 0);
      chk("idle_busy", busy0, 0);
   endtask

   task automatic op_c(input logic [1:0] m, input logic [5:0] v, input logic [10:0] e);
      q2.push_back(e);
      start_c = 1'b1; mode_c = m;
      cyc();
      start_c = 1'b0; mode_c = ~m; iv_c = 1'b1; id_c = v;
      chk("c_in_ready", ir2, 1);
      cyc();
      iv_c = 1'b0;
      chk("c_latency", ov2, 1);
      cyc();
      chk("c_valid_drop", ov2, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1; mode_a = 2'd0; in_data_a = 6'd0;
      start_c = 1'b0; iv_c = 1'b0; or_c = 1'b1; mode_c = 2'd0; id_c = 6'd0;
      #12;
      chk("rst_out_data", od0, 0);
      chk("rst_out_valid", ov0, 0);
      chk("rst_in_ready", ir0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_overflow", ovf0, 0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_start_ready", sr0, 1);

      // Back-to-back operands, then modes 1..3 chained with no idle cycle.
      op_a(2'd0, {6'd27, 6'd11, 6'd10, 6'd5, 6'd3, 6'd1}, 1'b0, {1'b0, 10'd57}, {1'b0, 10'd57});
      op_a(2'd1, {6'd27, 6'd11, 6'd10, 6'd5, 6'd3, 6'd1}, 1'b0, {1'b0, 10'd27}, {1'b0, 10'd27});
      op_a(2'd2, {6'd27, 6'd11, 6'd10, 6'd5, 6'd3, 6'd1}, 1'b0, {1'b0, 10'd1}, {1'b0, 10'd1});
      op_a(2'd3, {6'd27, 6'd11, 6'd10, 6'd5, 6'd3, 6'd1}, 1'b0, {1'b0, 10'd26}, {1'b0, 10'd26});
      drain(0);

      // 127 fits 10 bits but wraps to 63 with overflow in the 6-bit build.
      op_a(2'd0, {6'd63, 6'd63, 6'd1, 6'd0, 6'd0, 6'd0}, 1'b0, {1'b0, 10'd127}, {1'b1, 10'd63});
      drain(0);
      op_a(2'd1, {6'd63, 6'd63, 6'd1, 6'd0, 6'd0, 6'd0}, 1'b0, {1'b0, 10'd63}, {1'b0, 10'd63});
      drain(0);

      // Operand bubbles and result backpressure.
      op_a(2'd3, {6'd4, 6'd9, 6'd2, 6'd7, 6'd3, 6'd8}, 1'b1, {1'b0, 10'd7}, {1'b0, 10'd7});
      drain(5);

      // Asynchronous reset after three operands.
      start_a = 1'b1; mode_a = 2'd0;
      cyc();
      start_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid_a = 1'b1; in_data_a = 6'(i + 10);
         cyc();
      end
      in_valid_a = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_data", od0, 0);
      chk("async_out_data_w6", od1, 0);
      chk("async_out_valid", ov0, 0);
      chk("async_in_ready", ir0, 0);
      chk("async_busy", busy0, 0);
      chk("async_overflow", ovf0, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      chk("rel_start_ready", sr0, 1);
      op_a(2'd0, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6}, 1'b0, {1'b0, 10'd21}, {1'b0, 10'd21});
      drain(0);

      // Edge values.
      op_a(2'd2, 36'd0, 1'b0, {1'b0, 10'd0}, {1'b0, 10'd0});
      drain(0);
      op_a(2'd1, {6{6'd63}}, 1'b0, {1'b0, 10'd63}, {1'b0, 10'd63});
      drain(0);
      op_a(2'd0, {6{6'd63}}, 1'b0, {1'b0, 10'd378}, {1'b1, 10'd58});
      drain(0);

      // Single-operand build.
      op_c(2'd3, 6'd42, {1'b0, 10'd0});
      op_c(2'd0, 6'd42, {1'b0, 10'd42});
      op_c(2'd1, 6'd42, {1'b0, 10'd42});
      op_c(2'd2, 6'd42, {1'b0, 10'd42});

      cyc();
      cyc();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_seq_n.md
Name: calc_seq_n

Overview:
Parametrised sequential successor to the fixed six-operand combinational calculator. It accepts NUM_OPS unsigned operands serially over a valid/ready stream and reduces them according to a mode latched at start. Supported reductions are sum, max, min and range (max - min). The result is presented on a valid/ready output, with a sticky overflow flag for the sum mode. It sits between an operand source (register file or testbench driver) and the result consumer.

Parameters:
DATA_W, 6, operand width in bits (>=1).
NUM_OPS, 6, operands per operation (>=1).
OUT_W, 10, result width in bits (>=DATA_W).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  request a new operation; accepted only when start_ready=1.
start_ready  output  1  high in IDLE, and in DONE while out_ready=1.
mode  input  2  reduction select, sampled on accepted start: 0 sum, 1 max, 2 min, 3 range.
in_valid  input  1  operand valid.
in_ready  output  1  high only in ACCUM.
in_data  input  DATA_W  unsigned operand.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
out_data  output  OUT_W  result.
overflow  output  1  sum exceeded 2^OUT_W-1; valid with out_valid.
busy  output  1  high in ACCUM or DONE.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (asynchronous, any state including mid-operation):
  - state=IDLE.
  - out_data=0, overflow=0, out_valid=0, in_ready=0, busy=0.
  - Operand counter, accumulator, max and min registers cleared.
  - start_ready=1 once reset releases.
- FSM states IDLE, ACCUM, DONE:
  - IDLE: start=1 -> ACCUM. Latch mode; count=0; sum=0; max=0; min=all ones; overflow=0.
  - ACCUM: each cycle with in_valid & in_ready accepts one operand.
    - sum += zero-extended operand, modulo 2^OUT_W. Overflow is set sticky on carry out of bit OUT_W-1.
    - max and min are updated with the unsigned compare.
    - count increments.
    - On acceptance of operand NUM_OPS-1 -> DONE.
  - DONE: out_valid=1, with out_data and overflow held stable until out_ready=1.
    - out_ready=1 and start=0 -> IDLE.
    - out_ready=1 and start=1 -> result consumed and a new operation is accepted in the same cycle (re-initialise as IDLE->ACCUM, latch new mode).
- Result encoding:
  - sum = accumulator.
  - max and min are zero-extended to OUT_W.
  - range = max - min (never negative).
  - overflow is forced 0 for modes 1-3.
- Latency:
  - First operand can be accepted the cycle after start is accepted.
  - out_valid asserts on the clock edge that accepts the final operand (registered), i.e. visible the next cycle.
  - Minimum one operation = NUM_OPS+1 cycles start-to-out_valid.
- out_data is registered and only updates on entry to DONE; it holds its last value in IDLE/ACCUM.
- Ignored inputs:
  - start is ignored in ACCUM, and in DONE without out_ready.
  - in_valid is ignored outside ACCUM (in_ready=0).
  - mode changes after start acceptance have no effect.
- in_valid gaps (bubbles) are allowed; the state and count hold.
- NUM_OPS=1: single operand; range result = 0.
- Counter width is clog2(NUM_OPS) with a minimum of 1 bit. The counter never wraps within an operation.

Test Plan:
- Defaults, mode 0, operands 27,11,10,5,3,1 back-to-back, out_ready=1 -> out_data=57, overflow=0, out_valid exactly 1 cycle, 7 cycles after start.
- Same operands, modes 1, 2 and 3 in consecutive operations with start held high alongside out_ready -> results 27, 1, 26. No idle cycle occurs between operations.
- Overflow case: OUT_W=6, mode 0, operands 63,63,1,0,0,0 -> out_data=(127 mod 64)=63, overflow=1. Repeat in mode 1 -> out_data=63, overflow=0.
- Backpressure: in_valid toggled 1/0 during the operands and out_ready held 0 for 5 cycles in DONE -> result unchanged and held stable. Start and in_valid are ignored (in_ready=0, start_ready=0) until out_ready=1.
- Reset mid-operation: assert rst_n=0 asynchronously after 3 operands accepted -> all outputs 0 immediately, without waiting for a clock edge. A new operation with operands 1..6 in mode 0 -> 21.
- Edge values: NUM_OPS=1, mode 3, operand 42 -> 0. Mode 2 with all operands 0 -> 0. Mode 1 with all operands 63 -> 63.
